// File: rtl/rename_dispatch_pkg.sv
// Shared widths, tag type and renamed-instruction payload for the rename/dispatch stage.
package rename_dispatch_pkg;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned FL_DEPTH  = PHYS_REGS - ARCH_REGS;
    localparam int unsigned AREG_W    = $clog2(ARCH_REGS);
    localparam int unsigned FL_PTR_W  = $clog2(FL_DEPTH);
    localparam int unsigned FL_CNT_W  = FL_PTR_W + 1;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t ZERO_TAG = '0;

    typedef struct packed {
        tag_t prs1;
        tag_t prs2;
        tag_t prd;
    } renamed_t;

endpackage

// File: rtl/rename_dispatch_free_list.sv
// Free physical-tag ring: preloaded with the non-architectural tags, recycles committed old destinations.
module free_list_fifo
    import rename_dispatch_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pop,
    input  logic                push,
    input  tag_t                push_tag,
    output tag_t                head_tag_c,
    output logic [FL_CNT_W-1:0] count,
    output logic                overflow
);

    tag_t                ring [FL_DEPTH];
    logic [FL_PTR_W-1:0] rd_ptr;
    logic [FL_PTR_W-1:0] wr_ptr;
    logic                full_c;
    logic                push_valid_c;
    logic                push_ok_c;
    logic                drop_c;

    assign head_tag_c   = ring[rd_ptr];
    assign full_c       = (count == FL_CNT_W'(FL_DEPTH));
    assign push_valid_c = push && (push_tag != ZERO_TAG);
    // A pop in the same cycle makes room, so a push at full is only dropped without one.
    assign push_ok_c    = push_valid_c && (!full_c || pop);
    assign drop_c       = push_valid_c && full_c && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                ring[i] <= TAG_W'(ARCH_REGS + i);
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= FL_CNT_W'(FL_DEPTH);
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + FL_PTR_W'(1);
            end
            if (push_ok_c) begin
                ring[wr_ptr] <= push_tag;
                wr_ptr       <= wr_ptr + FL_PTR_W'(1);
            end
            case ({pop, push_ok_c})
                2'b10:   count <= count - FL_CNT_W'(1);
                2'b01:   count <= count + FL_CNT_W'(1);
                default: count <= count;
            endcase
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rename_dispatch.sv
// Register rename and dispatch: map table lookup, free-list allocation, ROB request and issue register.
module rename_dispatch
    import rename_dispatch_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AREG_W-1:0] in_rd,
    input  logic [AREG_W-1:0] in_rs1,
    input  logic [AREG_W-1:0] in_rs2,
    input  logic              in_writes_rd,
    output logic              rob_alloc_valid,
    output tag_t              rob_alloc_dest,
    output tag_t              rob_alloc_oldDest,
    input  logic              rob_alloc_ready,
    input  logic              free_valid,
    input  tag_t              free_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output tag_t              out_prs1,
    output tag_t              out_prs2,
    output tag_t              out_prd,
    output logic              fl_overflow
);

    tag_t                map_q [ARCH_REGS];
    renamed_t            out_q;
    logic                out_valid_q;
    renamed_t            renamed_c;
    logic [FL_CNT_W-1:0] fl_count;
    tag_t                fl_head_c;
    logic                needs_dest_c;
    logic                fire_c;
    logic                alloc_c;

    assign needs_dest_c = in_writes_rd && (in_rd != AREG_W'(0));
    assign in_ready     = rob_alloc_ready && (!out_valid_q || out_ready)
                          && (!needs_dest_c || (fl_count != '0));
    assign fire_c       = in_valid && in_ready;
    assign alloc_c      = fire_c && needs_dest_c;

    assign rob_alloc_valid   = fire_c;
    assign rob_alloc_dest    = alloc_c ? fl_head_c : ZERO_TAG;
    assign rob_alloc_oldDest = alloc_c ? map_q[in_rd] : ZERO_TAG;

    // Sources see the map before this cycle's rd update, so rs == rd yields the old tag.
    always_comb begin
        renamed_c      = '0;
        renamed_c.prs1 = map_q[in_rs1];
        renamed_c.prs2 = map_q[in_rs2];
        renamed_c.prd  = rob_alloc_dest;
    end

    free_list_fifo u_free_list (
        .clk        (clk),
        .reset_n    (reset_n),
        .pop        (alloc_c),
        .push       (free_valid),
        .push_tag   (free_tag),
        .head_tag_c (fl_head_c),
        .count      (fl_count),
        .overflow   (fl_overflow)
    );

    // Identity map at reset; x0 is never written because rd == 0 never allocates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= TAG_W'(i);
            end
        end else if (alloc_c) begin
            map_q[in_rd] <= fl_head_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (fire_c) begin
            out_valid_q <= 1'b1;
            out_q       <= renamed_c;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_prs1  = out_q.prs1;
    assign out_prs2  = out_q.prs2;
    assign out_prd   = out_q.prd;

endmodule

// File: tb/tb_rename_dispatch.sv
// Directed bench for rename_dispatch with a small map/free-list model for expected tags.
module tb_rename_dispatch;
    import rename_dispatch_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_rd;
    logic [4:0] in_rs1;
    logic [4:0] in_rs2;
    logic       in_writes_rd;
    logic       rob_alloc_valid;
    logic [5:0] rob_alloc_dest;
    logic [5:0] rob_alloc_oldDest;
    logic       rob_alloc_ready;
    logic       free_valid;
    logic [5:0] free_tag;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_prs1;
    logic [5:0] out_prs2;
    logic [5:0] out_prd;
    logic       fl_overflow;

    int n_chk  = 0;
    int n_pass = 0;

    logic [5:0] map_m [32];
    logic [5:0] fl_q [$];
    logic [5:0] last_prd;
    logic [5:0] last_prs1;

    always #5 clk = ~clk;

    rename_dispatch dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_rd             (in_rd),
        .in_rs1            (in_rs1),
        .in_rs2            (in_rs2),
        .in_writes_rd      (in_writes_rd),
        .rob_alloc_valid   (rob_alloc_valid),
        .rob_alloc_dest    (rob_alloc_dest),
        .rob_alloc_oldDest (rob_alloc_oldDest),
        .rob_alloc_ready   (rob_alloc_ready),
        .free_valid        (free_valid),
        .free_tag          (free_tag),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_prs1          (out_prs1),
        .out_prs2          (out_prs2),
        .out_prd           (out_prd),
        .fl_overflow       (fl_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) map_m[i] = 6'(i);
        fl_q = {};
        for (int i = 32; i < 64; i++) fl_q.push_back(6'(i));
    endtask

    // One accepted rename, optionally with a same-cycle free; checks ROB request then issue register.
    task automatic rename(input int rd, input int rs1, input int rs2, input bit wr,
                          input bit fv, input logic [5:0] ft);
        logic [5:0] e_dest;
        logic [5:0] e_old;
        logic [5:0] e_p1;
        logic [5:0] e_p2;
        bit         nd;
        in_valid     = 1'b1;
        in_rd        = 5'(rd);
        in_rs1       = 5'(rs1);
        in_rs2       = 5'(rs2);
        in_writes_rd = wr;
        free_valid   = fv;
        free_tag     = ft;
        #1;
        nd     = wr && (rd != 0);
        e_p1   = map_m[rs1];
        e_p2   = map_m[rs2];
        e_dest = 6'd0;
        e_old  = 6'd0;
        if (nd) begin
            e_dest    = fl_q.pop_front();
            e_old     = map_m[rd];
            map_m[rd] = e_dest;
        end
        if (fv && ft != 6'd0 && fl_q.size() < 32) fl_q.push_back(ft);
        chk("in_ready", 32'(in_ready), 32'd1);
        chk("alloc_valid", 32'(rob_alloc_valid), 32'd1);
        chk("alloc_dest", 32'(rob_alloc_dest), 32'(e_dest));
        chk("alloc_old", 32'(rob_alloc_oldDest), 32'(e_old));
        tick();
        in_valid   = 1'b0;
        free_valid = 1'b0;
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_prs1", 32'(out_prs1), 32'(e_p1));
        chk("out_prs2", 32'(out_prs2), 32'(e_p2));
        chk("out_prd", 32'(out_prd), 32'(e_dest));
        last_prd  = e_dest;
        last_prs1 = e_p1;
    endtask

    task automatic free_only(input logic [5:0] ft);
        in_valid   = 1'b0;
        free_valid = 1'b1;
        free_tag   = ft;
        if (ft != 6'd0 && fl_q.size() < 32) fl_q.push_back(ft);
        tick();
        free_valid = 1'b0;
    endtask

    // Offer a writing instruction and expect it to be refused this cycle.
    task automatic blocked(input string tag);
        in_valid     = 1'b1;
        in_writes_rd = 1'b1;
        in_rd        = 5'd1;
        #1;
        chk(tag, 32'(in_ready), 32'd0);
        chk({tag, "_alloc"}, 32'(rob_alloc_valid), 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        in_valid        = 1'b0;
        in_rd           = '0;
        in_rs1          = '0;
        in_rs2          = '0;
        in_writes_rd    = 1'b0;
        rob_alloc_ready = 1'b1;
        free_valid      = 1'b0;
        free_tag        = '0;
        out_ready       = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(fl_overflow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_prd", 32'(out_prd), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic rename, rd == 0, and a non-writing instruction.
        rename(3, 3, 4, 1'b1, 1'b0, 6'd0);
        chk("first_dest", 32'(last_prd), 32'd32);
        rename(0, 3, 5, 1'b1, 1'b0, 6'd0);
        chk("map3_updated", 32'(out_prs1), 32'd32);
        rename(7, 1, 2, 1'b0, 1'b0, 6'd0);

        // Reset mid-stream drops the held output and restores the map.
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        reset_n = 1'b1;
        model_reset();
        tick();

        // Drain the whole free list back to back.
        for (int i = 0; i < 32; i++) begin
            rename((i % 31) + 1, (i * 7) % 32, (i + 5) % 32, 1'b1, 1'b0, 6'd0);
            chk("drain_dest", 32'(last_prd), 32'(32 + i));
        end
        blocked("empty_block");
        rename(4, 1, 2, 1'b0, 1'b0, 6'd0);
        free_valid = 1'b1;
        free_tag   = 6'd7;
        blocked("no_bypass");
        fl_q.push_back(6'd7);
        tick();
        free_valid = 1'b0;
        rename(9, 9, 9, 1'b1, 1'b0, 6'd0);
        chk("recycled_dest", 32'(last_prd), 32'd7);
        free_only(6'd0);
        blocked("zero_tag_ignored");

        // Refill to 10, then steady alloc+free across pointer wrap.
        for (int j = 0; j < 10; j++) free_only(6'(20 + j));
        for (int k = 0; k < 25; k++) begin
            rename((k % 31) + 1, k % 32, (k + 1) % 32, 1'b1, 1'b1, (k == 0) ? 6'd40 : 6'(33 + k));
        end
        for (int k = 0; k < 10; k++) rename((k % 31) + 1, 0, k, 1'b1, 1'b0, 6'd0);
        blocked("count_held_10");

        // Fill, full with simultaneous alloc, then a dropped free.
        for (int j = 0; j < 32; j++) free_only(6'(63 - j));
        chk("full_no_ovf", 32'(fl_overflow), 32'd0);
        rename(12, 12, 0, 1'b1, 1'b1, 6'd5);
        chk("full_alloc_dest", 32'(last_prd), 32'd63);
        chk("full_alloc_no_ovf", 32'(fl_overflow), 32'd0);
        free_only(6'd6);
        chk("overflow_set", 32'(fl_overflow), 32'd1);
        tick();
        chk("overflow_sticky", 32'(fl_overflow), 32'd1);
        rename(13, 12, 13, 1'b1, 1'b0, 6'd0);
        chk("after_full_dest", 32'(last_prd), 32'd62);

        // Issue backpressure, then ROB backpressure.
        rename(2, 2, 3, 1'b1, 1'b0, 6'd0);
        out_ready = 1'b0;
        blocked("out_stall");
        tick();
        chk("held_valid", 32'(out_valid), 32'd1);
        chk("held_prd", 32'(out_prd), 32'(last_prd));
        chk("held_prs1", 32'(out_prs1), 32'(last_prs1));
        out_ready       = 1'b1;
        rob_alloc_ready = 1'b0;
        blocked("rob_stall");
        tick();
        chk("drained_valid", 32'(out_valid), 32'd0);
        rob_alloc_ready = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rename_dispatch.md
# rename_dispatch

Register-rename and dispatch stage in front of the 64-entry reorder buffer. Each decoded instruction is renamed here. The stage maps architectural source registers to physical tags and allocates a fresh physical destination from a free list. In the same cycle it issues the ROB allocation request (dest, oldDest) and presents the renamed instruction to issue through a registered output stage. On the other side, it consumes the ROB commit stream's freed old-destination tags and returns them to the free list.

## Interface
- ARCH_REGS, 32, architectural registers (x0 hardwired zero)
- PHYS_REGS, 64, physical registers; tag width 6
- FL_DEPTH, 32, free-list capacity (PHYS_REGS − ARCH_REGS)

- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  rename accepts this cycle
- in_rd / in_rs1 / in_rs2  in  5 each  architectural register indices
- in_writes_rd  in  1  instruction writes rd
- rob_alloc_valid  out  1  ROB allocation request
- rob_alloc_dest / rob_alloc_oldDest  out  6 each  new and previous physical tag of rd
- rob_alloc_ready  in  1  ROB has a free entry
- free_valid  in  1  commit retiring an entry
- free_tag  in  6  old destination tag to recycle
- out_valid  out  1  renamed instruction held for issue
- out_ready  in  1  issue accepts
- out_prs1 / out_prs2 / out_prd  out  6 each  renamed sources and destination
- fl_overflow  out  1  sticky: free arrived with free list full

## Operation
- State:
  - map table, 32×6;
  - free-list ring: 32×6 entries, 5-bit rd/wr pointers, 6-bit count;
  - output register.
- Reset values:
  - map[i]=i;
  - free list holds tags 32..63 in order, rd_ptr=0, wr_ptr=0, count=32;
  - out_valid=0, out_prs1/out_prs2/out_prd=0;
  - fl_overflow=0.
- needs_dest = in_writes_rd && in_rd!=0.
- in_ready = rob_alloc_ready && (!out_valid || out_ready) && (!needs_dest || count!=0).
- fire = in_valid && in_ready; rob_alloc_valid = fire (combinational).
- On fire with needs_dest:
  - rob_alloc_dest = free head;
  - rob_alloc_oldDest = map[in_rd];
  - map[in_rd] updated to the new tag;
  - rd_ptr advances and count decrements.
- On fire without needs_dest: rob_alloc_dest = rob_alloc_oldDest = 0.
  - Phys 0 is permanently bound to x0 and never enters the free list.
- Sources read the map before this cycle's update, so rs==rd yields the old tag.
- free_valid with free_tag!=0: tag written at wr_ptr, wr_ptr advances, count increments.
- free_tag==0 is ignored.
- free_valid while count==32 (not simultaneous with an allocation): write dropped, fl_overflow set.
- Simultaneous alloc and free: both take effect and count is unchanged.
  - A freed tag is not bypassed to an allocation in the same cycle; in_ready uses the registered count.
- Output stage: on fire, the register loads prs1/prs2/prd and out_valid=1. Without fire, out_valid clears when out_ready is high.

## Timing
- ROB allocation is zero-cycle (same cycle as fire).
- Renamed output appears the cycle after fire.
- Throughput is one instruction per cycle while the free list is non-empty and there is no backpressure.
- A freed tag becomes allocatable the cycle after free_valid.
- Pointers wrap modulo 32.
- Asynchronous reset mid-operation restores the reset map and free list and drops any in-flight output.

## Structure
- Shared package:
  - ARCH_REGS, PHYS_REGS, TAG_W=6, FL_DEPTH;
  - the zero-tag constant;
  - a renamed-instruction struct {prs1, prs2, prd}.
- One sub-module, free_list_fifo: ring with count, push/pop, reset preload, and the overflow flag.
- Map table and output register stay in the top.

## Test plan
- Reset, no stimulus: count=32, map[5]=5, in_ready=1, out_valid=0, fl_overflow=0.
- Rename rd=3 rs1=3 rs2=4: alloc dest=32, oldDest=3. Next cycle out_prs1=3, out_prs2=4, out_prd=32; map[3]=32.
- 32 back-to-back writing renames: dests 32..63 in order, then in_ready=0 with count=0. A free of tag 7 raises in_ready next cycle and the next dest is 7.
- Simultaneous alloc and free (tag 40) at count=10: count stays 10. Repeating past 32 pops exercises pointer wrap and preserves FIFO order.
- rd=0 or in_writes_rd=0: dest=oldDest=0, count unchanged. free_tag=0 is ignored.
- out_ready=0 while out_valid=1: in_ready=0 and output held stable. Also rob_alloc_ready=0 blocks fire. Reset asserted mid-stream restores the reset state.
